hdbn_encoder: RTL and testbench

- Parametrised HDBn line-code encoder for the serial transmit path.
- Generalises the single "4 zeros -> V" marker stage into a full substitution engine: zero-run detection, V insertion, parity-driven B insertion through a lookahead delay line, and AMI polarity assignment.
- Sits between the serial NRZ data source and the bipolar output driver.
- ZRUN=4 gives HDB3; ZRUN=3 gives B3ZS-style coding.

---
 rtl/hdbn_encoder.sv | 152 +++++++++++++++
 tb/tb_hdbn_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hdbn_encoder.sv
// HDBn line-code encoder: zero-run substitution (B/V), lookahead delay line, AMI polarity.
// Optional V/B substitution counters are enabled by defining HDBN_SUB_CNT_EN.
module hdbn_encoder #(
  parameter int ZRUN = 4,
  parameter int CW   = $clog2(ZRUN + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Ce,
  input  logic          Data_In,
`ifdef HDBN_SUB_CNT_EN
  input  logic          Cnt_Clr,
  output logic [15:0]   V_Cnt,
  output logic [15:0]   B_Cnt,
`endif
  output logic          Out_Valid,
  output logic [1:0]    Code_Out,
  output logic [1:0]    Pol_Out,
  output logic [CW-1:0] Run_Cnt
);

  if (ZRUN < 3 || ZRUN > 8) begin : g_zrun_bad
    $error("hdbn_encoder: ZRUN must be within 3..8");
  end

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_ONE  = 2'b01;
  localparam logic [1:0] C_B    = 2'b10;
  localparam logic [1:0] C_V    = 2'b11;
  localparam logic [1:0] P_ZERO = 2'b00;
  localparam logic [1:0] P_POS  = 2'b01;
  localparam logic [1:0] P_NEG  = 2'b11;

  logic [1:0]    dly_q [ZRUN];
  logic [1:0]    dly_d [ZRUN];
  logic [CW-1:0] run_q, run_d;
  logic          par_q, par_d;
  logic          last_pos_q, last_pos_d;
  logic          valid_q;
  logic [1:0]    code_q, code_d;
  logic [1:0]    pol_q, pol_d;
  logic [1:0]    oldest_s;

  assign oldest_s = dly_q[ZRUN-1];

  // Input stage: shift the delay line and apply V / lookahead-B substitution.
  always_comb begin
    dly_d = dly_q;
    run_d = run_q;
    par_d = par_q;
    if (Ce) begin
      for (int i = 1; i < ZRUN; i++) begin
        dly_d[i] = dly_q[i-1];
      end
      if (Data_In) begin
        dly_d[0] = C_ONE;
        par_d    = ~par_q;
        run_d    = '0;
      end else if (run_q == CW'(ZRUN - 1)) begin
        // The whole run now sits in the line, so the oldest stage is still a zero.
        dly_d[0] = C_V;
        run_d    = '0;
        par_d    = 1'b0;
        if (!par_q) begin
          dly_d[ZRUN-1] = C_B;
        end else begin
          dly_d[ZRUN-1] = dly_q[ZRUN-2];
        end
      end else begin
        dly_d[0] = C_ZERO;
        run_d    = run_q + CW'(1);
      end
    end else begin
      dly_d = dly_q;
    end
  end

  // Output stage: AMI polarity; V repeats the last mark polarity.
  always_comb begin
    code_d     = code_q;
    pol_d      = pol_q;
    last_pos_d = last_pos_q;
    if (Ce) begin
      code_d = oldest_s;
      case (oldest_s)
        C_ONE, C_B: begin
          pol_d      = last_pos_q ? P_NEG : P_POS;
          last_pos_d = ~last_pos_q;
        end
        C_V:     pol_d = last_pos_q ? P_POS : P_NEG;
        default: pol_d = P_ZERO;
      endcase
    end else begin
      code_d = code_q;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < ZRUN; i++) begin
        dly_q[i] <= C_ZERO;
      end
      run_q      <= '0;
      par_q      <= 1'b0;
      last_pos_q <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= C_ZERO;
      pol_q      <= P_ZERO;
    end else begin
      dly_q      <= dly_d;
      run_q      <= run_d;
      par_q      <= par_d;
      last_pos_q <= last_pos_d;
      valid_q    <= Ce;
      code_q     <= code_d;
      pol_q      <= pol_d;
    end
  end

  assign Out_Valid = valid_q;
  assign Code_Out  = code_q;
  assign Pol_Out   = pol_q;
  assign Run_Cnt   = run_q;

`ifdef HDBN_SUB_CNT_EN
  logic [15:0] v_cnt_q, b_cnt_q;

  // Substitution counters; clear has priority over increment.
  always_ff @(posedge Clk) begin
    if (Rst || Cnt_Clr) begin
      v_cnt_q <= 16'd0;
      b_cnt_q <= 16'd0;
    end else begin
      if (Ce && oldest_s == C_V) begin
        v_cnt_q <= v_cnt_q + 16'd1;
      end else begin
        v_cnt_q <= v_cnt_q;
      end
      if (Ce && oldest_s == C_B) begin
        b_cnt_q <= b_cnt_q + 16'd1;
      end else begin
        b_cnt_q <= b_cnt_q;
      end
    end
  end

  assign V_Cnt = v_cnt_q;
  assign B_Cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_hdbn_encoder.sv
// Scoreboard bench for hdbn_encoder (ZRUN=4 and ZRUN=3 instances).
// Expected symbols are written as letters: z zero, p/n one +/-, P/N B +/-, V/W V +/-.
module tb_hdbn_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, ce4, d4, ov4;
  logic [1:0] code4, pol4;
  logic [2:0] rc4;
  logic       rst3, ce3, d3, ov3;
  logic [1:0] code3, pol3;
  logic [1:0] rc3;
`ifdef HDBN_SUB_CNT_EN
  logic        clr4, clr3;
  logic [15:0] vc4, bc4, vc3, bc3;
`endif

  hdbn_encoder #(.ZRUN(4)) u_dut4 (
    .Clk(clk), .Rst(rst4), .Ce(ce4), .Data_In(d4),
`ifdef HDBN_SUB_CNT_EN
    .Cnt_Clr(clr4), .V_Cnt(vc4), .B_Cnt(bc4),
`endif
    .Out_Valid(ov4), .Code_Out(code4), .Pol_Out(pol4), .Run_Cnt(rc4)
  );

  hdbn_encoder #(.ZRUN(3)) u_dut3 (
    .Clk(clk), .Rst(rst3), .Ce(ce3), .Data_In(d3),
`ifdef HDBN_SUB_CNT_EN
    .Cnt_Clr(clr3), .V_Cnt(vc3), .B_Cnt(bc3),
`endif
    .Out_Valid(ov3), .Code_Out(code3), .Pol_Out(pol3), .Run_Cnt(rc3)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] q4[$];
  logic [3:0] q3[$];
  logic [3:0] last4 = 4'h0;
  logic [3:0] last3 = 4'h0;
  bit         mon_on = 1'b0;
  logic       ce4_s = 1'b0;
  logic       ce3_s = 1'b0;
  int         mrun4 = 0;
  int         mrun3 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sym(input byte c);
    case (c)
      "z":     sym = 4'b0000;
      "p":     sym = 4'b0101;
      "n":     sym = 4'b0111;
      "P":     sym = 4'b1001;
      "N":     sym = 4'b1011;
      "V":     sym = 4'b1101;
      "W":     sym = 4'b1111;
      default: sym = 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    ce4_s <= ce4;
    ce3_s <= ce3;
  end

  // Monitor for the ZRUN=4 instance.
  always @(negedge clk) begin
    if (mon_on) begin
      check("valid4", {31'd0, ov4}, {31'd0, ce4_s});
      if (ov4) begin
        if (q4.size() > 0) begin
          last4 = q4.pop_front();
          check("sym4", {28'd0, code4, pol4}, {28'd0, last4});
        end else begin
          check("unexpected4", 32'd1, 32'd0);
        end
      end else begin
        check("hold4", {28'd0, code4, pol4}, {28'd0, last4});
      end
    end
  end

  // Monitor for the ZRUN=3 instance.
  always @(negedge clk) begin
    if (mon_on) begin
      check("valid3", {31'd0, ov3}, {31'd0, ce3_s});
      if (ov3) begin
        if (q3.size() > 0) begin
          last3 = q3.pop_front();
          check("sym3", {28'd0, code3, pol3}, {28'd0, last3});
        end else begin
          check("unexpected3", 32'd1, 32'd0);
        end
      end else begin
        check("hold3", {28'd0, code3, pol3}, {28'd0, last3});
      end
    end
  end

  task automatic do_reset(input int sel);
    if (sel == 4) begin rst4 = 1'b1; ce4 = 1'b0; end
    else          begin rst3 = 1'b1; ce3 = 1'b0; end
    @(posedge clk); #1;
    if (sel == 4) begin
      rst4 = 1'b0; last4 = 4'h0; mrun4 = 0;
      if (mon_on) begin
        check("rst4_out", {26'd0, ov4, code4, pol4, rc4}, 32'd0);
      end
    end else begin
      rst3 = 1'b0; last3 = 4'h0; mrun3 = 0;
      if (mon_on) begin
        check("rst3_out", {27'd0, ov3, code3, pol3, rc3}, 32'd0);
      end
    end
  endtask

  // One strobe per expected symbol; input bits beyond din are padded with ones.
  task automatic run_seq(input int sel, input string din, input string exp, input bit gap);
    logic b;
    for (int i = 0; i < exp.len(); i++) begin
      b = (i < din.len()) ? (din[i] == "1") : 1'b1;
      if (sel == 4) begin
        q4.push_back(sym(exp[i]));
        ce4 = 1'b1; d4 = b;
      end else begin
        q3.push_back(sym(exp[i]));
        ce3 = 1'b1; d3 = b;
      end
      @(posedge clk); #1;
      if (sel == 4) begin
        ce4 = 1'b0;
        if (b || mrun4 == 3) mrun4 = 0; else mrun4++;
        check("runcnt4", {29'd0, rc4}, mrun4);
      end else begin
        ce3 = 1'b0;
        if (b || mrun3 == 2) mrun3 = 0; else mrun3++;
        check("runcnt3", {30'd0, rc3}, mrun3);
      end
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst4 = 1'b1; ce4 = 1'b0; d4 = 1'b0;
    rst3 = 1'b1; ce3 = 1'b0; d3 = 1'b0;
`ifdef HDBN_SUB_CNT_EN
    clr4 = 1'b0; clr3 = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b0; rst3 = 1'b0;
    check("init4", {26'd0, ov4, code4, pol4, rc4}, 32'd0);
    check("init3", {27'd0, ov3, code3, pol3, rc3}, 32'd0);
    mon_on = 1'b1;

    run_seq(4, "11111111", "zzzzpnpnpnpn", 1'b0);
    do_reset(4);
    run_seq(4, "00001", "zzzzPzzVn", 1'b0);
`ifdef HDBN_SUB_CNT_EN
    check("cnt_t2", {bc4, vc4}, {16'd1, 16'd1});
`endif
    do_reset(4);
    run_seq(4, "100001", "zzzzpzzzVn", 1'b0);
`ifdef HDBN_SUB_CNT_EN
    check("cnt_t3", {bc4, vc4}, {16'd0, 16'd1});
`endif
    do_reset(4);
    run_seq(4, "00000000", "zzzzPzzVNzzW", 1'b0);
`ifdef HDBN_SUB_CNT_EN
    check("cnt_t4", {bc4, vc4}, {16'd2, 16'd2});
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    check("cnt_clr", {bc4, vc4}, 32'd0);
`endif
    do_reset(4);
    run_seq(4, "100", "zzz", 1'b0);
    do_reset(4);
    run_seq(4, "0000", "zzzzPzzV", 1'b0);

    do_reset(3);
    run_seq(3, "0001", "zzzPzVn", 1'b0);
    do_reset(3);
    run_seq(3, "0001", "zzzPzVn", 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("q4_drained", q4.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
